dff_bist_checker: RTL and testbench

- Synthesizable stimulus/response engine for one D flip-flop with asynchronous active-low reset (d, clk, rstn, q).
- Drives the flop's d and rstn, samples its q, and compares q against a cycle-accurate expected model.
- Flags mismatches, including a flop whose reset is not truly asynchronous.
- Sits beside the flop under test in a self-test wrapper; the flop shares clk with this block.

---
 rtl/dff_bist_pkg.sv | 20 ++
 rtl/dff_bist_checker_lfsr8.sv | 22 ++
 rtl/dff_bist_checker.sv | 150 +++++++++++++++
 tb/tb_dff_bist_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the D flip-flop self-test checker.
`timescale 1ns/1ps
package dff_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DUT_RST,
        RUN,
        DRAIN
    } state_t;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // Fibonacci step: feedback enters at bit 7, sequence leaves via bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {^(s & LFSR_TAPS), s[7:1]};
    endfunction

endpackage

// File: rtl/dff_bist_checker_lfsr8.sv
// 8-bit Fibonacci LFSR providing the data stream for the flop under test.
`timescale 1ns/1ps
module lfsr8
    import dff_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/dff_bist_checker.sv
// Stimulus/response engine for one async-reset D flip-flop.
`timescale 1ns/1ps
module dff_bist_checker
    import dff_bist_pkg::*;
#(
    parameter int         NUM_VECTORS = 64,
    parameter int         RST_CYCLES  = 4,
    parameter int         RST_AT      = 20,
    parameter logic [7:0] SEED        = DEFAULT_SEED,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_d,
    output logic             dut_rstn,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] RUN_LAST = 8'(NUM_VECTORS - 1);

    state_t           state;
    logic [7:0]       cnt;
    logic [8:0]       chk_idx;
    logic             d_prev;
    logic             rstn_prev;
    logic [7:0]       lfsr_q;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic             checking;
    logic             exp_q;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;
    logic             next_rstn;

    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_adv  = ((state == DUT_RST) && (cnt == RST_LAST))
                    || ((state == RUN) && (cnt != RUN_LAST));

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .state   (lfsr_q)
    );

    // A true async-clear flop reads 0 whenever rstn is low now or was low
    // at the capturing edge; otherwise it shows last cycle's d.
    assign checking = (state != IDLE);
    assign exp_q    = rstn_prev & dut_rstn & d_prev;
    assign mismatch = checking && (dut_q != exp_q);

    always_comb begin
        err_next = err_count;
        if (mismatch && !(&err_count)) begin
            err_next = err_count + CNT_W'(1);
        end
    end

    // Reset pulse position for the RUN index about to be driven.
    always_comb begin
        next_rstn = 1'b1;
        if (state == DUT_RST) begin
            next_rstn = (RST_AT != 0);
        end else if (state == RUN) begin
            next_rstn = ((32'(cnt) + 32'd1) != RST_AT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            chk_idx       <= '0;
            d_prev        <= 1'b0;
            rstn_prev     <= 1'b0;
            dut_d         <= 1'b0;
            dut_rstn      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            d_prev    <= dut_d;
            rstn_prev <= dut_rstn;
            if (checking) begin
                err_count <= err_next;
                chk_idx   <= chk_idx + 9'd1;
                if (mismatch && (err_count == '0)) begin
                    first_err_idx <= CNT_W'(chk_idx);
                end
            end
            unique case (state)
                IDLE: begin
                    dut_d    <= 1'b0;
                    dut_rstn <= 1'b0;
                    if (start) begin
                        state         <= DUT_RST;
                        cnt           <= '0;
                        chk_idx       <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                    end
                end
                DUT_RST: begin
                    if (cnt == RST_LAST) begin
                        state    <= RUN;
                        cnt      <= '0;
                        dut_d    <= lfsr_q[0];
                        dut_rstn <= next_rstn;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (cnt == RUN_LAST) begin
                        state    <= DRAIN;
                        dut_d    <= 1'b0;
                        dut_rstn <= 1'b1;
                    end else begin
                        cnt      <= cnt + 8'd1;
                        dut_d    <= lfsr_q[0];
                        dut_rstn <= next_rstn;
                    end
                end
                DRAIN: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    pass     <= (err_next == '0);
                    dut_d    <= 1'b0;
                    dut_rstn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bist_checker.sv
// Directed bench: three checker instances, each beside a configurable flop model.
`timescale 1ns/1ps
module tb_dff_bist_checker;

    localparam int NV = 64;
    localparam int RC = 4;
    localparam int RA = 20;
    localparam int TOTAL = RC + NV + 1;

    typedef enum int {M_ASYNC, M_SYNC, M_STUCK0, M_INV} mode_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    mode_t mode = M_ASYNC;

    logic [2:0] dd, drn, dq, busy, done, pass;
    logic [7:0] err0, fe0, err1, fe1;
    logic [3:0] err2, fe2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dff_bist_checker #(.NUM_VECTORS(NV), .RST_CYCLES(RC), .RST_AT(RA),
                       .SEED(8'hA5), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .dut_d(dd[0]), .dut_rstn(drn[0]), .dut_q(dq[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .first_err_idx(fe0)
    );

    dff_bist_checker #(.NUM_VECTORS(NV), .RST_CYCLES(RC), .RST_AT(RA),
                       .SEED(8'h80), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .dut_d(dd[1]), .dut_rstn(drn[1]), .dut_q(dq[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .first_err_idx(fe1)
    );

    dff_bist_checker #(.NUM_VECTORS(NV), .RST_CYCLES(RC), .RST_AT(RA),
                       .SEED(8'hA5), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start),
        .dut_d(dd[2]), .dut_rstn(drn[2]), .dut_q(dq[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err2), .first_err_idx(fe2)
    );

    for (genvar g = 0; g < 3; g++) begin : g_fut
        logic st_a = 1'b0;
        logic st_s = 1'b0;
        always @(posedge clk or negedge drn[g]) begin
            if (!drn[g]) st_a <= 1'b0;
            else         st_a <= dd[g];
        end
        always @(posedge clk) begin
            st_s <= drn[g] ? dd[g] : 1'b0;
        end
        assign dq[g] = (mode == M_ASYNC) ? st_a :
                       (mode == M_SYNC)  ? st_s :
                       (mode == M_INV)   ? ~st_a : 1'b0;
    end

    // x^8+x^6+x^5+x^4+1, feedback into bit 7, output at bit 0.
    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
    endfunction

    function automatic logic run_bit(input logic [7:0] seed, input int i);
        logic [7:0] s;
        s = seed;
        for (int k = 0; k < i; k++) s = step(s);
        return s[0];
    endfunction

    // Number of checks expecting q=1 (errors of a stuck-at-0 flop).
    function automatic int stuck_errs(input logic [7:0] seed, output int first);
        logic [7:0] s;
        logic dp, rp, d, r;
        int c;
        s = seed; dp = 1'b0; rp = 1'b0; c = 0; first = -1;
        for (int i = 0; i < NV; i++) begin
            d = s[0];
            r = (i != RA);
            s = step(s);
            if (dp && rp && r) begin
                if (first < 0) first = RC + i;
                c++;
            end
            dp = d;
            rp = r;
        end
        if (dp && rp) begin
            if (first < 0) first = RC + NV;
            c++;
        end
        if (first < 0) first = 0;
        return c;
    endfunction

    task automatic launch(input int pulse_at, output int cycles);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        cycles = 0;
        while (done[0] !== 1'b1 && cycles < 300) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = (cycles == pulse_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, done, pass, dd, drn} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {busy, done, pass, dd, drn});
        end
        n_chk++;
        if ({err0, fe0, err1, fe1, err2, fe2} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0", {err0, fe0, err1, fe1, err2, fe2});
        end
        rst = 1'b0;
    endtask

    task automatic test_good();
        int cyc;
        mode = M_ASYNC;
        launch(-1, cyc);
        n_chk++;
        if (cyc != TOTAL) begin
            n_fail++;
            $display("FAIL good_latency: got %0d want %0d", cyc, TOTAL);
        end
        n_chk++;
        if (pass !== 3'b111) begin
            n_fail++;
            $display("FAIL good_pass: got %b want 111", pass);
        end
        n_chk++;
        if ({err0, err1, err2, fe0, fe1, fe2} !== 40'd0) begin
            n_fail++;
            $display("FAIL good_cnt: got %h want 0", {err0, err1, err2, fe0, fe1, fe2});
        end
    endtask

    task automatic test_sync_reset();
        int cyc;
        logic e0;
        e0 = run_bit(8'hA5, RA - 1);
        mode = M_SYNC;
        launch(-1, cyc);
        n_chk++;
        if (err1 !== 8'd1 || fe1 !== 8'd24 || pass[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_forced: got err=%0d idx=%0d pass=%b want 1 24 0",
                     err1, fe1, pass[1]);
        end
        n_chk++;
        if (err0 !== 8'(e0) || fe0 !== (e0 ? 8'd24 : 8'd0) || pass[0] !== !e0) begin
            n_fail++;
            $display("FAIL sync_default: got err=%0d idx=%0d pass=%b want %0d",
                     err0, fe0, pass[0], e0);
        end
        n_chk++;
        if (err2 !== 4'(e0)) begin
            n_fail++;
            $display("FAIL sync_narrow: got %0d want %0d", err2, e0);
        end
    endtask

    task automatic test_stuck0();
        int cyc, c0, f0, c1, f1, c2;
        c0 = stuck_errs(8'hA5, f0);
        c1 = stuck_errs(8'h80, f1);
        c2 = (c0 > 15) ? 15 : c0;
        mode = M_STUCK0;
        launch(-1, cyc);
        n_chk++;
        if (err0 !== 8'(c0) || fe0 !== 8'(f0)) begin
            n_fail++;
            $display("FAIL stuck_u0: got %0d/%0d want %0d/%0d", err0, fe0, c0, f0);
        end
        n_chk++;
        if (err1 !== 8'(c1) || fe1 !== 8'(f1)) begin
            n_fail++;
            $display("FAIL stuck_u1: got %0d/%0d want %0d/%0d", err1, fe1, c1, f1);
        end
        n_chk++;
        if (err2 !== 4'(c2) || fe2 !== 4'(f0)) begin
            n_fail++;
            $display("FAIL stuck_u2: got %0d/%0d want %0d/%0d", err2, fe2, c2, 4'(f0));
        end
        n_chk++;
        if (pass !== {c0 == 0, c1 == 0, c0 == 0}) begin
            n_fail++;
            $display("FAIL stuck_pass: got %b want %b", pass, {c0 == 0, c1 == 0, c0 == 0});
        end
    endtask

    task automatic test_invert();
        int cyc;
        mode = M_INV;
        launch(-1, cyc);
        n_chk++;
        if (err0 !== 8'(TOTAL) || err1 !== 8'(TOTAL)) begin
            n_fail++;
            $display("FAIL inv_err: got %0d %0d want %0d", err0, err1, TOTAL);
        end
        n_chk++;
        if (err2 !== 4'd15) begin
            n_fail++;
            $display("FAIL inv_saturate: got %0d want 15", err2);
        end
        n_chk++;
        if ({fe0, fe1, fe2} !== 20'd0 || pass !== 3'b000 || done !== 3'b111) begin
            n_fail++;
            $display("FAIL inv_idx: got %h pass=%b done=%b want 0 000 111",
                     {fe0, fe1, fe2}, pass, done);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        mode = M_ASYNC;
        launch(RC + 10, cyc);
        n_chk++;
        if (cyc != TOTAL) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d want %0d", cyc, TOTAL);
        end
        n_chk++;
        if (pass !== 3'b111 || err0 !== 8'd0) begin
            n_fail++;
            $display("FAIL busy_start_pass: got %b err=%0d want 111 0", pass, err0);
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 3'b000) begin
            n_fail++;
            $display("FAIL busy_start_idle: got %b want 000", busy);
        end
    endtask

    task automatic test_rst_midrun();
        int cyc;
        mode = M_INV;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (RC + 30) @(negedge clk);
        n_chk++;
        if (busy !== 3'b111 || err0 == 8'd0) begin
            n_fail++;
            $display("FAIL midrun_busy: got %b err=%0d want 111 nonzero", busy, err0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, pass, dd, drn} !== 15'd0 ||
            {err0, fe0, err1, fe1, err2, fe2} !== 40'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b %h want 0", {busy, done, pass, dd, drn},
                     {err0, fe0, err1, fe1, err2, fe2});
        end
        rst = 1'b0;
        mode = M_ASYNC;
        launch(-1, cyc);
        n_chk++;
        if (cyc != TOTAL || pass !== 3'b111 || err0 !== 8'd0) begin
            n_fail++;
            $display("FAIL midrun_rerun: got cyc=%0d pass=%b err=%0d want %0d 111 0",
                     cyc, pass, err0, TOTAL);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_sync_reset();
        test_stuck0();
        test_invert();
        test_start_ignored();
        test_rst_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
